// File: rtl/tail_light_pkg.sv
// Shared mode encoding and request decoder for the tail-light sequencer.
package tail_light_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_BRAKE   = 3'd1,
    MODE_HAZARD  = 3'd2,
    MODE_TURN_L  = 3'd3,
    MODE_TURN_R  = 3'd4,
    MODE_BRAKE_L = 3'd5,
    MODE_BRAKE_R = 3'd6
  } mode_e;

  // Brake wins, then hazard (or both turn levers), then a single turn lever.
  function automatic mode_e decode_mode(input logic left, input logic right,
                                        input logic brake, input logic hazard);
    mode_e m;
    m = MODE_OFF;
    if (brake && (left ^ right))
      m = left ? MODE_BRAKE_L : MODE_BRAKE_R;
    else if (brake)
      m = MODE_BRAKE;
    else if (hazard || (left && right))
      m = MODE_HAZARD;
    else if (left)
      m = MODE_TURN_L;
    else if (right)
      m = MODE_TURN_R;
    return m;
  endfunction

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tail_light_seq_if.sv
// Request levels in, lamp pattern and active mode out.
interface tail_light_seq_if #(parameter int LAMPS = 3);
  logic                 left;
  logic                 right;
  logic                 brake;
  logic                 hazard;
  logic [2*LAMPS-1:0]   pattern;
  logic [2:0]           mode;

  modport master (output left, right, brake, hazard, input pattern, mode);
  modport slave  (input left, right, brake, hazard, output pattern, mode);
endinterface

// File: rtl/tail_light_seq_tick_gen.sv
// Animation prescaler: tick on the last count of each TICK_DIV-cycle window.
import tail_light_pkg::*;

module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = width_of(TICK_DIV);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign tick = (count_reg == CW'(TICK_DIV - 1));

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clr || tick)
      count_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end
endmodule

// File: rtl/tail_light_seq.sv
// Tail-light sequencer: registered mode, sweep step and hazard phase drive the lamps.
import tail_light_pkg::*;

module tail_light_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  tail_light_seq_if.slave  bus
);
  localparam int SW = width_of(LAMPS + 1);

  mode_e          mode_reg, mode_next;
  logic [SW-1:0]  step_reg, step_next;
  logic           phase_reg, phase_next;
  logic           clr;
  logic           tick;
  logic [LAMPS-1:0] left_half;
  logic [LAMPS-1:0] right_half;
  logic [2*LAMPS-1:0] pattern_c;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    mode_next  = decode_mode(bus.left, bus.right, bus.brake, bus.hazard);
    clr        = (mode_next != mode_reg);
    step_next  = step_reg;
    phase_next = phase_reg;
    // A mode change restarts the animation even if a tick lands on the same cycle.
    if (clr) begin
      step_next  = '0;
      phase_next = 1'b1;
    end else if (tick) begin
      step_next  = (step_reg == SW'(LAMPS)) ? '0 : step_reg + 1'b1;
      phase_next = ~phase_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg  <= MODE_OFF;
      step_reg  <= '0;
      phase_reg <= 1'b1;
    end else begin
      mode_reg  <= mode_next;
      step_reg  <= step_next;
      phase_reg <= phase_next;
    end
  end

  // Lamp gi counts outward from the centre; it is lit once the sweep passes it.
  for (genvar gi = 0; gi < LAMPS; gi++) begin : g_sweep
    assign left_half[gi]            = (step_reg > SW'(gi));
    assign right_half[LAMPS-1-gi]   = (step_reg > SW'(gi));
  end

  always_comb begin
    pattern_c = '0;
    case (mode_reg)
      MODE_BRAKE:   pattern_c = '1;
      MODE_HAZARD:  pattern_c = {(2*LAMPS){phase_reg}};
      MODE_TURN_L:  pattern_c = {left_half, {LAMPS{1'b0}}};
      MODE_TURN_R:  pattern_c = {{LAMPS{1'b0}}, right_half};
      MODE_BRAKE_L: pattern_c = {left_half, {LAMPS{1'b1}}};
      MODE_BRAKE_R: pattern_c = {{LAMPS{1'b1}}, right_half};
      default:      pattern_c = '0;
    endcase
  end

  assign bus.pattern = pattern_c;
  assign bus.mode    = mode_reg;
endmodule

// File: tb/tb_tail_light_seq.sv
// Vector-table bench for two sequencer configurations (3 lamps / div 2, 1 lamp / div 1).
module tb_tail_light_seq;

  typedef struct {
    logic        rst;
    logic        l;
    logic        r;
    logic        b;
    logic        h;
    logic [5:0]  pat;
    logic [2:0]  mode;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  tail_light_seq_if #(.LAMPS(3)) bus_a ();
  tail_light_seq_if #(.LAMPS(1)) bus_b ();

  tail_light_seq #(.LAMPS(3), .TICK_DIV(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  tail_light_seq #(.LAMPS(1), .TICK_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  task automatic add(input logic rst, input logic l, input logic r, input logic b,
                     input logic h, input logic [5:0] pat, input logic [2:0] mode,
                     input string name);
    vec_t v;
    v.rst = rst; v.l = l; v.r = r; v.b = b; v.h = h;
    v.pat = pat; v.mode = mode; v.name = name;
    tbl.push_back(v);
  endtask

  // Drive one cycle of requests, queue the expectation, compare after the edge.
  task automatic apply(input bit sel_b, input vec_t v);
    vec_t e;
    logic [5:0] got_pat;
    logic [2:0] got_mode;
    @(negedge clk);
    if (sel_b) begin
      rst_b = v.rst; bus_b.left = v.l; bus_b.right = v.r; bus_b.brake = v.b; bus_b.hazard = v.h;
    end else begin
      rst_a = v.rst; bus_a.left = v.l; bus_a.right = v.r; bus_a.brake = v.b; bus_a.hazard = v.h;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (sel_b) begin
      got_pat  = {4'b0000, bus_b.pattern};
      got_mode = bus_b.mode;
    end else begin
      got_pat  = bus_a.pattern;
      got_mode = bus_a.mode;
    end
    n_vec++;
    if (got_pat !== e.pat || got_mode !== e.mode) begin
      n_miss++;
      $display("FAIL %s: pattern=%b mode=%0d, expected pattern=%b mode=%0d",
               e.name, got_pat, got_mode, e.pat, e.mode);
    end else begin
      $display("ok   %s: pattern=%b mode=%0d", e.name, got_pat, got_mode);
    end
  endtask

  task automatic apply_b(input logic rst, input logic l, input logic r, input logic b,
                         input logic h, input logic [1:0] pat, input logic [2:0] mode,
                         input string name);
    vec_t v;
    v.rst = rst; v.l = l; v.r = r; v.b = b; v.h = h;
    v.pat = {4'b0000, pat}; v.mode = mode; v.name = name;
    apply(1'b1, v);
  endtask

  initial begin
    bus_a.left = 0; bus_a.right = 0; bus_a.brake = 0; bus_a.hazard = 0;
    bus_b.left = 0; bus_b.right = 0; bus_b.brake = 0; bus_b.hazard = 0;

    // rst l r b h   pattern    mode
    add(1,0,0,0,0, 6'b000000, 3'd0, "reset0");
    add(1,1,0,0,0, 6'b000000, 3'd0, "reset_over_left");
    add(0,1,0,0,0, 6'b000000, 3'd3, "turnl_s0a");
    add(0,1,0,0,0, 6'b000000, 3'd3, "turnl_s0b");
    add(0,1,0,0,0, 6'b001000, 3'd3, "turnl_s1a");
    add(0,1,0,0,0, 6'b001000, 3'd3, "turnl_s1b");
    add(0,1,0,0,0, 6'b011000, 3'd3, "turnl_s2a");
    add(0,1,0,0,0, 6'b011000, 3'd3, "turnl_s2b");
    add(0,1,0,0,0, 6'b111000, 3'd3, "turnl_s3a");
    add(0,1,0,0,0, 6'b111000, 3'd3, "turnl_s3b");
    add(0,1,0,0,0, 6'b000000, 3'd3, "turnl_wrap_a");
    add(0,1,0,0,0, 6'b000000, 3'd3, "turnl_wrap_b");
    add(0,1,0,0,0, 6'b001000, 3'd3, "turnl_2nd_s1a");
    add(0,1,0,0,0, 6'b001000, 3'd3, "turnl_2nd_s1b");
    add(0,1,0,0,0, 6'b011000, 3'd3, "turnl_2nd_s2a");
    add(0,0,1,0,0, 6'b000000, 3'd4, "switch_to_r");
    add(0,0,1,0,0, 6'b000000, 3'd4, "turnr_s0b");
    add(0,0,1,0,0, 6'b000100, 3'd4, "turnr_s1a");
    // reset mid-sweep with left held
    add(1,0,0,0,0, 6'b000000, 3'd0, "reset1");
    add(0,1,0,0,0, 6'b000000, 3'd3, "rl_s0a");
    add(0,1,0,0,0, 6'b000000, 3'd3, "rl_s0b");
    add(0,1,0,0,0, 6'b001000, 3'd3, "rl_s1a");
    add(0,1,0,0,0, 6'b001000, 3'd3, "rl_s1b");
    add(0,1,0,0,0, 6'b011000, 3'd3, "rl_s2a");
    add(1,1,0,0,0, 6'b000000, 3'd0, "rst_mid_sweep");
    add(0,1,0,0,0, 6'b000000, 3'd3, "restart_s0a");
    add(0,1,0,0,0, 6'b000000, 3'd3, "restart_s0b");
    add(0,1,0,0,0, 6'b001000, 3'd3, "restart_s1a");
    // brake + right
    add(0,0,1,1,0, 6'b111000, 3'd6, "braker_s0a");
    add(0,0,1,1,0, 6'b111000, 3'd6, "braker_s0b");
    add(0,0,1,1,0, 6'b111100, 3'd6, "braker_s1a");
    add(0,0,1,1,0, 6'b111100, 3'd6, "braker_s1b");
    add(0,0,1,1,0, 6'b111110, 3'd6, "braker_s2a");
    add(0,0,1,1,0, 6'b111110, 3'd6, "braker_s2b");
    add(0,0,1,1,0, 6'b111111, 3'd6, "braker_s3a");
    add(0,0,1,1,0, 6'b111111, 3'd6, "braker_s3b");
    add(0,0,1,1,0, 6'b111000, 3'd6, "braker_wrap");
    // both levers -> hazard, then brake
    add(0,1,1,0,0, 6'b111111, 3'd2, "haz_lr_on_a");
    add(0,1,1,0,0, 6'b111111, 3'd2, "haz_lr_on_b");
    add(0,1,1,0,0, 6'b000000, 3'd2, "haz_lr_off_a");
    add(0,1,1,0,0, 6'b000000, 3'd2, "haz_lr_off_b");
    add(0,1,1,0,0, 6'b111111, 3'd2, "haz_lr_on_c");
    add(0,1,1,1,0, 6'b111111, 3'd1, "brake_all_a");
    add(0,1,1,1,0, 6'b111111, 3'd1, "brake_all_b");
    // hazard beats a single lever without restarting the phase
    add(0,0,0,0,1, 6'b111111, 3'd2, "haz_on_a");
    add(0,1,0,0,1, 6'b111111, 3'd2, "haz_left_on_b");
    add(0,1,0,0,1, 6'b000000, 3'd2, "haz_left_off_a");
    // brake + left
    add(0,1,0,1,0, 6'b000111, 3'd5, "brakel_s0a");
    add(0,1,0,1,0, 6'b000111, 3'd5, "brakel_s0b");
    add(0,1,0,1,0, 6'b001111, 3'd5, "brakel_s1a");
    // reset mid-hazard
    add(0,0,0,0,1, 6'b111111, 3'd2, "haz_entry");
    add(1,0,0,0,1, 6'b000000, 3'd0, "rst_mid_hazard");
    add(0,0,0,0,1, 6'b111111, 3'd2, "haz_after_rst");
    add(0,0,0,0,0, 6'b000000, 3'd0, "idle_off");

    for (int i = 0; i < tbl.size(); i++)
      apply(1'b0, tbl[i]);

    // Single lamp, tick every cycle
    apply_b(1,0,0,0,0, 2'b00, 3'd0, "b_reset");
    apply_b(0,0,1,0,0, 2'b00, 3'd4, "b_turnr_s0");
    apply_b(0,0,1,0,0, 2'b01, 3'd4, "b_turnr_s1");
    apply_b(0,0,1,0,0, 2'b00, 3'd4, "b_turnr_wrap");
    apply_b(0,0,1,0,0, 2'b01, 3'd4, "b_turnr_s1_again");
    apply_b(0,1,0,0,0, 2'b00, 3'd3, "b_turnl_s0");
    apply_b(0,1,0,0,0, 2'b10, 3'd3, "b_turnl_s1");
    apply_b(0,1,0,1,0, 2'b01, 3'd5, "b_brakel_s0");
    apply_b(0,1,0,1,0, 2'b11, 3'd5, "b_brakel_s1");
    apply_b(0,1,0,1,0, 2'b01, 3'd5, "b_brakel_wrap");
    apply_b(0,0,0,0,1, 2'b11, 3'd2, "b_haz_on");
    apply_b(0,0,0,0,1, 2'b00, 3'd2, "b_haz_off");
    apply_b(0,0,0,0,1, 2'b11, 3'd2, "b_haz_on_again");
    apply_b(0,0,0,0,0, 2'b00, 3'd0, "b_off");

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tail_light_seq.md
TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 SHALL have parameter LAMPS, default 3: lamps per side, legal range 1..16.
REQ-002 SHALL have parameter TICK_DIV, default 1: clock cycles per animation step, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port left  input  1  left turn request, level.
REQ-006 SHALL have port right  input  1  right turn request, level.
REQ-007 SHALL have port brake  input  1  brake request, level.
REQ-008 SHALL have port hazard  input  1  hazard request, level.
REQ-009 SHALL have port pattern  output  2*LAMPS  lamp drive: bits [2*LAMPS-1:LAMPS] are left, bits [LAMPS-1:0] are right, and the inner lamps are bits LAMPS and LAMPS-1.
REQ-010 SHALL have port mode  output  3  the registered active mode, encoded as in REQ-012.

Function
REQ-011 SHALL decode the requested mode each cycle in this priority order:
- brake with exactly one of left/right -> BRAKE_L or BRAKE_R.
- brake otherwise -> BRAKE.
- hazard, or left and right together -> HAZARD.
- left only -> TURN_L; right only -> TURN_R.
- none of the above -> OFF.
REQ-012 SHALL encode the modes as OFF=0, BRAKE=1, HAZARD=2, TURN_L=3, TURN_R=4, BRAKE_L=5, BRAKE_R=6; the value 7 is unused and SHALL be treated as OFF.
REQ-013 SHALL register the decoded mode every cycle; mode and pattern are Moore outputs and reflect an input change exactly 1 cycle later.
REQ-014 SHALL contain a prescaler that counts 0..TICK_DIV-1 and asserts an internal tick when the count equals TICK_DIV-1, then wraps to 0; with TICK_DIV=1 the tick is asserted every cycle.
REQ-015 SHALL keep a step counter with range 0..LAMPS that advances only on tick and wraps from LAMPS to 0.
REQ-016 SHALL, on any cycle where the decoded mode differs from the registered mode, clear the step counter, prescaler and hazard phase; this takes priority over a coincident tick.
REQ-017 SHALL drive pattern per mode:
- OFF: all 0.
- BRAKE: all 1.
- TURN_L: the innermost <step> left lamps on, all other lamps off.
- TURN_R: the same sweep on the right half.
REQ-018 SHALL, in BRAKE_L/BRAKE_R, light the turning side as in TURN_L/TURN_R and hold the opposite side fully on.
REQ-019 SHALL, in HAZARD, drive all lamps from a phase bit: the phase is 1 (all on) on entry and toggles on each tick.
REQ-020 SHALL hold each step or hazard phase for exactly TICK_DIV cycles, giving a sweep period of (LAMPS+1)*TICK_DIV cycles and a hazard period of 2*TICK_DIV cycles.
REQ-021 SHALL treat a held request as continuing to animate indefinitely; a request dropped mid-sweep takes effect 1 cycle later with no completion of the sweep.

Reset
REQ-022 SHALL, while rst=1, load on each clock edge: mode=OFF, step=0, prescaler=0, hazard phase=1; pattern therefore reads all 0 from the cycle after rst is sampled.
REQ-023 SHALL give rst priority over all inputs, including when asserted mid-sweep or mid-hazard.
REQ-024 SHALL, after rst deasserts with a request held, take the decoded mode 1 cycle later starting at step 0.
REQ-025 SHALL leave pattern and mode undefined before the first reset; the bench SHALL apply reset first.

Structure
REQ-026 SHALL define the mode enum (3-bit) and its encodings in shared package tail_light_pkg.
REQ-027 SHALL implement the prescaler as sub-module tick_gen (parameter TICK_DIV; ports clk, rst, clr, tick).
REQ-028 SHALL size the step counter as $clog2(LAMPS+1) bits and the prescaler as $clog2(TICK_DIV) bits, with a minimum width of 1.

Verification (LAMPS=3, TICK_DIV=2 unless stated)
REQ-029 SHALL cover: left=1 held after reset -> pattern cycles 000000, 001000, 011000, 111000 for 2 cycles each, repeating every 8 cycles; mode=3.
REQ-030 SHALL cover: brake=1, right=1 -> pattern cycles 111000, 111100, 111110, 111111 for 2 cycles each; mode=6.
REQ-031 SHALL cover: left=right=1, brake=0 -> pattern 111111 ×2, 000000 ×2, repeating; mode=2; then asserting brake -> pattern 111111 steady 1 cycle later, mode=1.
REQ-032 SHALL cover: left held, switched to right while at 011000 -> next cycle 000000 with mode=4, then 000100 after 2 further cycles.
REQ-033 SHALL cover: rst pulsed for 1 cycle mid-sweep at 011000 with left still held -> 000000 / mode=0 during reset, then the sweep restarts at step 0.
REQ-034 SHALL cover: LAMPS=1, TICK_DIV=1, right=1 -> pattern alternates 00, 01 every cycle.
